accel_bcd_sampler: RTL
======================

# accel_bcd_sampler

Parametrised multi-channel sample-and-convert stage between `spi_control` and the seven-segment drivers. It periodically snapshots NUM_CH accelerometer axes and converts each to BCD with a sequential double-dabble engine shared across channels. Results are held per channel, and one channel at a time is presented to the display path. This replaces per-axis combinational `/10` and `%10` logic with a multi-cycle converter. It adds sign, overflow, staleness and freeze behaviour.

## Interface
- `NUM_CH`, 3: number of channels (≥1).
- `DATA_W`, 16: bits per channel sample (≥4).
- `DIGITS`, 4: BCD digits per result (1..8).
- `SAMPLE_DIV`, 25_000_000: `clk` cycles between sample ticks (≥ NUM_CH*(DATA_W+2)+1).
- `SEL_W`, `$clog2(NUM_CH)`, minimum 1: width of `sel`.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `data_update`  in  1  one-cycle strobe: new samples on `ch_data`.
- `ch_data`  in  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
- `freeze`  in  1  high suppresses new snapshots; held results stay valid.
- `sel`  in  SEL_W  channel routed to the display outputs.
- `bcd_out`  out  DIGITS*4  BCD of selected channel; digit 0 is bits [3:0].
- `sign_out`  out  1  selected channel negative.
- `ovf_out`  out  1  selected channel saturated.
- `stale_out`  out  1  selected channel snapshot taken with no `data_update` since the previous snapshot.
- `done`  out  1  one-cycle pulse: all channel results updated.
- `busy`  out  1  conversion in progress.

## Operation
- Tick counter runs 0..SAMPLE_DIV-1 and wraps.
- `tick` is asserted in the cycle the counter equals SAMPLE_DIV-1.
- The counter runs regardless of `freeze` and state.
- `fresh` flag: set by `data_update`, cleared on snapshot.
- If snapshot and `data_update` occur in the same cycle, the flag stays set and the new data is captured.
- Snapshot condition: `tick` & state IDLE & !`freeze`.
  - At the snapshot edge, all `ch_data` words are registered.
  - Each channel's stale bit is latched as !`fresh`.
  - State goes to LOAD, channel index 0.
- A tick while not IDLE or while `freeze` is high is dropped silently.
- FSM states: IDLE → LOAD → SHIFT → STORE → (LOAD for next channel | IDLE).
  - LOAD, 1 cycle: compute magnitude and sign of channel `idx`. Compare magnitude with 10^DIGITS−1; above that sets `ovf`. Clear BCD accumulator.
  - SHIFT, DATA_W cycles: each cycle, add 3 to every BCD nibble ≥5, then shift the {bcd, magnitude} pair left by 1.
  - STORE, 1 cycle: write the result, sign and ovf for channel `idx`. If `ovf`, write all digits 9. Increment `idx`.
  - If `idx` was NUM_CH−1: go to IDLE and pulse `done` in the same edge the last result is written.
- The BCD accumulator is internally wide enough for DATA_W bits; only the low DIGITS nibbles are stored.
- Output mux is combinational from the stored result registers, indexed by `sel`.
- `sel` ≥ NUM_CH drives `bcd_out`, `sign_out`, `ovf_out` and `stale_out` to 0.
- Stored results change only at STORE edges. Channels not yet converted keep their previous values during a pass.

## Timing
- Reset values: `bcd_out`, `sign_out`, `ovf_out`, `stale_out`, `done` and `busy` are 0. All result registers, the tick counter and `fresh` are 0. State is IDLE.
- Latency: snapshot edge to `done` is NUM_CH*(DATA_W+2) cycles (54 at defaults).
- `busy` is high from the cycle after the snapshot edge through the cycle the last STORE is executed.
- `busy` is low in the cycle `done` is high.
- `rst_n` low mid-conversion: the pass is aborted at that edge, all results clear to 0, and no `done` is produced.
- `sel` change is reflected on outputs in the same cycle (combinational path).

## Configuration
- `ACCEL_SIGNED_EN` defined: each channel is two's complement.
  - Magnitude is the absolute value, computed with DATA_W+1 bits so −2^(DATA_W−1) converts correctly.
  - `sign_out` = MSB of the sample.
- `ACCEL_SIGNED_EN` undefined: channels are unsigned, magnitude = raw word, and `sign_out` is tied 0.

## Test plan
- Defaults with SAMPLE_DIV=100 and `ACCEL_SIGNED_EN`. Load ch0=0x0123, pulse `data_update`, wait for tick. Required: `done` exactly 54 cycles after the snapshot; `sel`=0 gives `bcd_out`=0x0291, `sign_out`=0, `ovf_out`=0, `stale_out`=0.
- Signed: ch1=0xFFF6, `sel`=1 → `bcd_out`=0x0010, `sign_out`=1. ch2=0x8000, `sel`=2 → `ovf_out`=1, `bcd_out`=0x9999, `sign_out`=1.
- Overflow boundary: ch0=9999 → 0x9999 with `ovf_out`=0. ch0=10000 → 0x9999 with `ovf_out`=1.
- Freeze and stale: `freeze`=1 across two ticks with changing `ch_data` → no `done` and outputs unchanged. Release `freeze` without `data_update` → the next pass completes with `stale_out`=1.
- Reset mid-pass: assert `rst_n`=0 for 1 cycle 20 cycles after the snapshot → `busy`=0 and all outputs 0 next cycle, no `done`. The next tick converts normally.
- `sel`=3 with NUM_CH=3 → all outputs 0. Unsigned build (macro undefined), ch0=0xFFF6 → `ovf_out`=1, `sign_out`=0.

Source files
------------

// File: rtl/accel_bcd_sampler.sv
// Periodic multi-channel sampler with a shared sequential double-dabble BCD converter.
// Define ACCEL_SIGNED_EN to treat channel words as two's complement; undefined means unsigned.
module accel_bcd_sampler #(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 16,
    parameter int DIGITS     = 4,
    parameter int SAMPLE_DIV = 25_000_000,
    parameter int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     data_update,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     freeze,
    input  logic [SEL_W-1:0]         sel,
    output logic [DIGITS*4-1:0]      bcd_out,
    output logic                     sign_out,
    output logic                     ovf_out,
    output logic                     stale_out,
    output logic                     done,
    output logic                     busy
);

    localparam int CNT_W   = $clog2(SAMPLE_DIV);
    localparam int BCD_RAW = (DATA_W + 1) / 3 + 1;
    localparam int BCD_N   = (BCD_RAW > DIGITS) ? BCD_RAW : DIGITS;
    localparam int BCD_W   = BCD_N * 4;
    localparam int SH_W    = BCD_W + DATA_W;
    localparam int BIT_W   = $clog2(DATA_W + 1);
    localparam int RES_W   = DIGITS * 4;
    localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS) - 64'd1;
    localparam logic [RES_W-1:0] NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STORE
    } state_t;

    state_t                     state;
    logic [CNT_W-1:0]           cnt;
    logic                       fresh;
    logic [NUM_CH*DATA_W-1:0]   snap;
    logic                       snap_stale;
    logic [SEL_W-1:0]           idx;
    logic [BIT_W-1:0]           bit_cnt;
    logic [SH_W-1:0]            shreg;
    logic                       cur_sign;
    logic                       cur_ovf;
    logic [RES_W-1:0]           res_bcd [NUM_CH];
    logic [NUM_CH-1:0]          res_sign;
    logic [NUM_CH-1:0]          res_ovf;
    logic [NUM_CH-1:0]          res_stale;

    logic                       tick;
    logic                       snap_go;
    logic [DATA_W-1:0]          cur_word;
    logic                       neg;
    logic [DATA_W:0]            mag;
    logic                       ovf_now;
    logic [SH_W-1:0]            sh_adj;
    logic [SH_W-1:0]            sh_next;

    assign tick    = (cnt == CNT_W'(SAMPLE_DIV - 1));
    assign snap_go = tick && (state == S_IDLE) && !freeze;
    assign busy    = (state != S_IDLE);

    always_comb begin
        cur_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == SEL_W'(k)) cur_word = snap[k*DATA_W +: DATA_W];
        end
`ifdef ACCEL_SIGNED_EN
        // One extra bit so the most negative sample has a representable magnitude.
        neg = cur_word[DATA_W-1];
        mag = neg ? (~{1'b1, cur_word} + (DATA_W+1)'(1)) : {1'b0, cur_word};
`else
        neg = 1'b0;
        mag = {1'b0, cur_word};
`endif
        ovf_now = (64'(mag) > MAX_VAL);

        sh_adj = shreg;
        for (int i = 0; i < BCD_N; i++) begin
            if (sh_adj[DATA_W+4*i +: 4] >= 4'd5)
                sh_adj[DATA_W+4*i +: 4] = sh_adj[DATA_W+4*i +: 4] + 4'd3;
        end
        sh_next = {sh_adj[SH_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            fresh      <= 1'b0;
            snap       <= '0;
            snap_stale <= 1'b0;
            idx        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            cur_sign   <= 1'b0;
            cur_ovf    <= 1'b0;
            done       <= 1'b0;
            res_sign   <= '0;
            res_ovf    <= '0;
            res_stale  <= '0;
            for (int k = 0; k < NUM_CH; k++) res_bcd[k] <= '0;
        end else begin
            done <= 1'b0;
            cnt  <= tick ? '0 : cnt + CNT_W'(1);

            // A strobe coincident with the snapshot belongs to the next pass.
            if (snap_go)          fresh <= data_update;
            else if (data_update) fresh <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (snap_go) begin
                        snap       <= ch_data;
                        snap_stale <= !fresh;
                        idx        <= '0;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    shreg    <= {{BCD_W{1'b0}}, mag[DATA_W-1:0]};
                    cur_sign <= neg;
                    cur_ovf  <= ovf_now;
                    bit_cnt  <= '0;
                    state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    shreg   <= sh_next;
                    bit_cnt <= bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_W'(DATA_W - 1)) state <= S_STORE;
                end
                S_STORE: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (idx == SEL_W'(k)) begin
                            res_bcd[k]   <= cur_ovf ? NINES : shreg[DATA_W +: RES_W];
                            res_sign[k]  <= cur_sign;
                            res_ovf[k]   <= cur_ovf;
                            res_stale[k] <= snap_stale;
                        end
                    end
                    if (idx == SEL_W'(NUM_CH - 1)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + SEL_W'(1);
                        state <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bcd_out   = '0;
        sign_out  = 1'b0;
        ovf_out   = 1'b0;
        stale_out = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                bcd_out   = res_bcd[k];
                sign_out  = res_sign[k];
                ovf_out   = res_ovf[k];
                stale_out = res_stale[k];
            end
        end
    end

endmodule
